// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall print path: FSM states, syscall codes and
// the big-endian byte-lane selector used by the print engine.
package syscall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  localparam logic [7:0] NUL = 8'h00;

  // Memory words are big-endian: byte offset 0 lives in bits 31:24.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/syscall_print_engine.sv
// Print-string syscall engine: walks a NUL-terminated string in data memory one
// word at a time and streams its bytes to the console while stalling the CPU.
module syscall_print_engine
  import syscall_pkg::*;
#(
  parameter int MAX_LEN     = 256,
  parameter int MEM_LAT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        print_req,
  input  logic [31:0] str_addr,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        sysstall,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  if (MAX_LEN < 1 || MEM_LAT_MAX < 1) begin : g_param_check
    $error("syscall_print_engine: MAX_LEN and MEM_LAT_MAX must be at least 1");
  end

  // Handshakes: char_data is transferred on a rising edge where char_valid and
  // char_ready are both high; char_valid/char_data hold until then. mem_rd_en is
  // a single-cycle strobe and the matching mem_rd_valid is only honoured in WAIT.

  state_t        state_q, state_d;
  // addr_q[1:0] doubles as the byte offset, so advancing one byte is addr_q + 1
  // and carrying out of offset 3 naturally lands on the next word at offset 0.
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_q, buf_d;
  logic          err_q, err_d;

  logic [7:0]    cur_byte;
  logic [CW-1:0] count_inc;

  assign cur_byte  = byte_lane(buf_q, addr_q[1:0]);
  assign count_inc = count_q + CW'(1);

  assign sysstall  = print_req | (state_q != ST_IDLE);
  assign err       = err_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    buf_d      = buf_q;
    err_d      = err_q;
    mem_rd_en  = 1'b0;
    mem_addr   = 32'h0000_0000;
    char_valid = 1'b0;
    char_data  = NUL;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (print_req) begin
          addr_d  = str_addr;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_rd_valid) begin
          buf_d   = mem_rd_data;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (cur_byte == NUL) begin
          state_d = ST_DONE;
        end else begin
          char_valid = 1'b1;
          char_data  = cur_byte;
          if (char_ready) begin
            count_d = count_inc;
            if (count_inc == MAX_CNT) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              addr_d = addr_q + 32'd1;
              if (addr_q[1:0] == 2'd3) begin
                state_d = ST_FETCH;
              end
            end
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_syscall_print_engine.sv
// Bench for syscall_print_engine: table of string requests against a random-latency
// memory model, plus hand sequences for reset, console back-pressure and ignored requests.
module tb_syscall_print_engine;
  import syscall_pkg::*;

  localparam int MAX_LEN     = 4;
  localparam int MEM_LAT_MAX = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        print_req;
  logic [31:0] str_addr;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        sysstall;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  syscall_print_engine #(.MAX_LEN(MAX_LEN), .MEM_LAT_MAX(MEM_LAT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .print_req(print_req), .str_addr(str_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .sysstall(sysstall), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [logic [31:0]];
  int done_cnt     = 0;
  int stall_cycles = 0;
  int stall_mode   = 3; // 0 random ready, 1 never ready, 2 stall 5 cycles on first char, 3 always ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hEEEE_EEEE;
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] pend_addr;
  int          lat_cnt = 0;
  logic        outstanding = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= 32'h0;
      lat_cnt      <= 0;
      outstanding  <= 1'b0;
    end else begin
      mem_rd_valid <= 1'b0;
      if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= rd_word(pend_addr);
          outstanding  <= 1'b0;
        end
      end else if (!mem_rd_en && !outstanding && $urandom_range(0, 7) == 0) begin
        // Stray valid while nothing is pending must not be captured.
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= 32'hA5A5_A5A5;
      end
      if (mem_rd_en) begin
        pend_addr   <= mem_addr;
        lat_cnt     <= int'($urandom_range(1, MEM_LAT_MAX));
        outstanding <= 1'b1;
      end
    end
  end

  // ---------------- console ready driver ----------------
  always begin : ready_drv
    int prev_mode;
    int hold;
    logic armed;
    prev_mode = -1;
    hold = 0;
    armed = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode != prev_mode) begin
        prev_mode = stall_mode;
        hold = 0;
        armed = 1'b1;
      end
      case (stall_mode)
        0: char_ready = ($urandom_range(0, 3) != 0);
        1: char_ready = 1'b0;
        2: begin
          if (armed && char_valid) begin
            armed = 1'b0;
            hold = 5;
          end
          if (hold > 0) begin
            char_ready = 1'b0;
            hold--;
          end else begin
            char_ready = 1'b1;
          end
        end
        default: char_ready = 1'b1;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("char_hold_valid", 32'(char_valid), 32'd1);
        check("char_hold_data", 32'(char_data), 32'(prev_data));
      end
      prev_hold = char_valid && !char_ready;
      prev_data = char_data;
      if (char_valid && !char_ready) stall_cycles++;
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL char_unexpected: got 0x%02h expected none at %0t", char_data, $time);
        end else begin
          check("char", 32'(char_data), 32'(exp_q.pop_front()));
        end
      end
      if (mem_rd_en) begin
        check("one_outstanding", 32'(outstanding), 32'd0);
        if (rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h expected none at %0t", mem_addr, $time);
        end else begin
          check("rd_addr", mem_addr, rd_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] w0;      // word at rd0
    logic [31:0] w1;      // word at rd0+4
    logic [31:0] chars;   // expected chars, first in bits 31:24
    int          n_chars;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          n_reads;
    logic        exp_err;
    logic        extra_req;
  } vec_t;

  vec_t vecs[9];

  task automatic drive_req(input logic [31:0] a);
    @(posedge clk);
    #1;
    print_req = 1'b1;
    str_addr  = a;
    #1;
    check("sysstall_on_req", 32'(sysstall), 32'd1);
    @(posedge clk);
    #1;
    print_req = 1'b0;
    str_addr  = $urandom;
  endtask

  task automatic run_vec(input vec_t v, input int mode);
    logic [31:0] a2;
    int done_base;
    logic seen;
    mem.delete();
    a2 = v.rd0 + 32'd4;
    mem[v.rd0] = v.w0;
    mem[a2]    = v.w1;
    rd_q.push_back(v.rd0);
    if (v.n_reads > 1) rd_q.push_back(v.rd1);
    for (int i = 0; i < v.n_chars; i++) exp_q.push_back(v.chars[31 - 8*i -: 8]);
    stall_mode = mode;
    done_base  = done_cnt;
    drive_req(v.addr);
    if (v.extra_req) begin
      @(posedge clk);
      #1;
      print_req = 1'b1;
      str_addr  = 32'h0000_0900;
      @(posedge clk);
      #1;
      print_req = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("err", 32'(err), 32'(v.exp_err));
    check("sysstall_in_done", 32'(sysstall), 32'd1);
    if (v.extra_req) begin
      print_req = 1'b1;
      str_addr  = 32'h0000_0900;
    end
    @(posedge clk);
    #1;
    print_req = 1'b0;
    @(negedge clk);
    check("sysstall_after_done", 32'(sysstall), 32'd0);
    check("idle_after_done", 32'(state_dbg), 32'(ST_IDLE));
    check("one_done_pulse", 32'(done_cnt - done_base), 32'd1);
    check("chars_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(rd_q.size()), 32'd0);
    exp_q.delete();
    rd_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_base;
    int stall_base;
    logic seen;

    vecs[0] = '{32'h0000_0100, 32'h4869_0000, 32'h0,         32'h4869_0000, 2, 32'h0000_0100, 32'h0,         1, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0102, 32'h4142_4344, 32'h4500_0000, 32'h4344_4500, 3, 32'h0000_0100, 32'h0000_0104, 2, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0200, 32'h00FF_FFFF, 32'h0,         32'h0,         0, 32'h0000_0200, 32'h0,         1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0300, 32'h3132_3334, 32'h3536_3738, 32'h3132_3334, 4, 32'h0000_0300, 32'h0,         1, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0401, 32'h0061_6200, 32'h0,         32'h6162_0000, 2, 32'h0000_0400, 32'h0,         1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0503, 32'hFFFF_FF7A, 32'h7B7C_0000, 32'h7A7B_7C00, 3, 32'h0000_0500, 32'h0000_0504, 2, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFE, 32'h0000_5152, 32'h5300_0000, 32'h5152_5300, 3, 32'hFFFF_FFFC, 32'h0000_0000, 2, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0600, 32'h4142_4300, 32'h0,         32'h4142_4300, 3, 32'h0000_0600, 32'h0,         1, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0701, 32'h0031_3233, 32'h3435_0000, 32'h3132_3334, 4, 32'h0000_0700, 32'h0000_0704, 2, 1'b1, 1'b0};

    rst_n     = 1'b0;
    print_req = 1'b0;
    str_addr  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    print_req = 1'b1;
    str_addr  = 32'h0000_0100;
    #1;
    check("sysstall_req_in_reset", 32'(sysstall), 32'd1);
    @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char_data", 32'(char_data), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    print_req = 1'b0;
    #1;
    check("rst_sysstall", 32'(sysstall), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) run_vec(vecs[k], (k % 2 == 0) ? 0 : 3);

    // err from the truncated request stays up until a new request is accepted.
    check("err_held", 32'(err), 32'd1);

    // Reset while a character is waiting on the console.
    mem.delete();
    mem[32'h0000_0100] = 32'h4869_0000;
    rd_q.push_back(32'h0000_0100);
    stall_mode = 1;
    done_base  = done_cnt;
    drive_req(32'h0000_0100);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (char_valid) seen = 1'b1;
    end
    check("emit_reached", 32'(seen), 32'd1);
    check("emit_char", 32'(char_data), 32'h48);
    check("err_cleared_on_req", 32'(err), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("mid_rst_char_valid", 32'(char_valid), 32'd0);
    check("mid_rst_char_data", 32'(char_data), 32'd0);
    check("mid_rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_sysstall", 32'(sysstall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - done_base), 32'd0);
    check("mid_rst_reads", 32'(rd_q.size()), 32'd0);
    rd_q.delete();

    run_vec(vecs[0], 0);

    // Console back-pressure on the first character.
    stall_base = stall_cycles;
    run_vec(vecs[0], 2);
    check("stall_cycles", 32'(stall_cycles - stall_base), 32'd5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
